// File: rtl/stage_if.sv
// stage_if: MIPS instruction fetch with the IF/ID register built in.
// Branch delay slot is always fetched and presented; redirects never squash.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    output logic        ice,
    output logic [31:0] iaddr,
    input  logic [31:0] inst,
    input  logic        id_stop,
    input  logic [2:0]  jsel,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jc_addr,
    input  logic [31:0] j_addr,
    output logic [31:0] if_o_pc,
    output logic [31:0] if_o_pc_4,
    output logic [31:0] if_o_instr,
    output logic        if_o_valid
);

    localparam logic [31:0] NONE = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

    logic [31:0] pc_f;
    if_id_t      if_id;
    logic [31:0] hold_instr;
    logic        hold_valid;

    logic [2:0]  jsel_v;
    logic [31:0] target;
    logic [31:0] next_pc;

    // A bubble in decode cannot request a redirect.
    assign jsel_v = if_id.valid ? jsel : 3'b000;

    always_comb begin
        target = pc_f + 32'd4;
        priority case (1'b1)
            jsel_v[0]: target = branch_addr;
            jsel_v[1]: target = jc_addr;
            jsel_v[2]: target = j_addr;
            default:   target = pc_f + 32'd4;
        endcase
        next_pc = {target[31:2], 2'b00};
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            pc_f       <= RESET_PC;
            if_id.pc   <= RESET_PC;
            if_id.valid <= 1'b0;
            hold_instr <= NONE;
            hold_valid <= 1'b0;
        end else if (!id_stop) begin
            pc_f        <= next_pc;
            if_id.pc    <= pc_f;
            if_id.valid <= 1'b1;
            hold_valid  <= 1'b0;
        end else if (!hold_valid) begin
            // ROM keeps reading pc_f, so the live word must be parked here.
            hold_instr <= inst;
            hold_valid <= 1'b1;
        end
    end

    assign ice   = ~cpu_rst;
    assign iaddr = pc_f;

    assign if_o_pc    = if_id.pc;
    assign if_o_pc_4  = if_id.pc + 32'd4;
    assign if_o_valid = if_id.valid;
    assign if_o_instr = !if_id.valid ? NONE
                      : hold_valid   ? hold_instr
                      : inst;

endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: directed vectors for stage_if against a
// synchronous ROM whose word i holds 32'h1000_0000 + i.
module tb_stage_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ice;
    logic [31:0] iaddr;
    logic [31:0] inst = 32'h0;
    logic        id_stop = 1'b0;
    logic [2:0]  jsel = 3'b000;
    logic [31:0] branch_addr = 32'h0;
    logic [31:0] jc_addr = 32'h0;
    logic [31:0] j_addr = 32'h0;
    logic [31:0] if_o_pc;
    logic [31:0] if_o_pc_4;
    logic [31:0] if_o_instr;
    logic        if_o_valid;

    int n_chk = 0;
    int n_fail = 0;

    stage_if #(.RESET_PC(32'h0000_0000)) dut (
        .cpu_clk_50M(clk),
        .cpu_rst    (rst),
        .ice        (ice),
        .iaddr      (iaddr),
        .inst       (inst),
        .id_stop    (id_stop),
        .jsel       (jsel),
        .branch_addr(branch_addr),
        .jc_addr    (jc_addr),
        .j_addr     (j_addr),
        .if_o_pc    (if_o_pc),
        .if_o_pc_4  (if_o_pc_4),
        .if_o_instr (if_o_instr),
        .if_o_valid (if_o_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ice) inst <= 32'h1000_0000 + (iaddr >> 2);

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_pc(string tag, logic [31:0] pc);
        check({tag, ".pc"}, if_o_pc, pc);
        check({tag, ".pc4"}, if_o_pc_4, pc + 32'd4);
        check({tag, ".instr"}, if_o_instr, 32'h1000_0000 + (pc >> 2));
        check({tag, ".valid"}, {31'b0, if_o_valid}, 32'd1);
    endtask

    task automatic exp_rst(string tag);
        check({tag, ".ice"}, {31'b0, ice}, 32'd0);
        check({tag, ".iaddr"}, iaddr, 32'h0);
        check({tag, ".valid"}, {31'b0, if_o_valid}, 32'd0);
        check({tag, ".instr"}, if_o_instr, 32'h0);
        check({tag, ".pc"}, if_o_pc, 32'h0);
        check({tag, ".pc4"}, if_o_pc_4, 32'h4);
    endtask

    initial begin
        tick();
        tick();
        exp_rst("rst");

        // release; a redirect from a bubble must be ignored
        rst = 1'b0;
        jsel = 3'b001;
        branch_addr = 32'h200;
        #1;
        check("rel.ice", {31'b0, ice}, 32'd1);
        check("rel.iaddr", iaddr, 32'h0);
        check("rel.valid", {31'b0, if_o_valid}, 32'd0);
        check("rel.instr", if_o_instr, 32'h0);
        tick();
        jsel = 3'b000;
        exp_pc("seq0", 32'h0);
        check("bubble_jsel.iaddr", iaddr, 32'h4);
        tick();
        exp_pc("seq4", 32'h4);
        tick();
        exp_pc("seq8", 32'h8);

        // taken branch at 8: delay slot 12, then 0x40, 0x44
        jsel = 3'b001;
        branch_addr = 32'h40;
        tick();
        jsel = 3'b000;
        exp_pc("br_ds", 32'hC);
        check("br.iaddr", iaddr, 32'h40);
        tick();
        exp_pc("br_tgt", 32'h40);
        tick();
        exp_pc("br_tgt4", 32'h44);

        // stall and jump together: stall wins
        id_stop = 1'b1;
        jsel = 3'b100;
        j_addr = 32'h80;
        tick();
        exp_pc("sj_hold", 32'h44);
        check("sj.iaddr", iaddr, 32'h48);
        id_stop = 1'b0;
        tick();
        jsel = 3'b000;
        exp_pc("sj_ds", 32'h48);
        check("sj.iaddr2", iaddr, 32'h80);
        tick();
        exp_pc("sj_tgt", 32'h80);

        // register jump with misaligned target
        jsel = 3'b010;
        jc_addr = 32'h103;
        tick();
        jsel = 3'b000;
        exp_pc("jr_ds", 32'h84);
        check("jr.iaddr", iaddr, 32'h100);
        tick();
        exp_pc("jr_tgt", 32'h100);

        // wrap of pc_f+4 and pc_d+4
        jsel = 3'b100;
        j_addr = 32'hFFFF_FFFC;
        tick();
        jsel = 3'b000;
        exp_pc("wr_ds", 32'h104);
        check("wr.iaddr", iaddr, 32'hFFFF_FFFC);
        tick();
        exp_pc("wr_top", 32'hFFFF_FFFC);
        check("wr.iaddr0", iaddr, 32'h0);
        tick();
        exp_pc("wr_0", 32'h0);
        tick();
        tick();
        tick();
        tick();
        exp_pc("st_pre", 32'h10);

        // three-cycle stall at 16
        id_stop = 1'b1;
        check("st1.iaddr", iaddr, 32'h14);
        tick();
        exp_pc("st2", 32'h10);
        check("st2.iaddr", iaddr, 32'h14);
        tick();
        exp_pc("st3", 32'h10);
        check("st3.iaddr", iaddr, 32'h14);
        tick();
        id_stop = 1'b0;
        exp_pc("st_rel", 32'h10);
        tick();
        exp_pc("st_20", 32'h14);
        tick();
        exp_pc("st_24", 32'h18);

        // reset while a held instruction is parked
        id_stop = 1'b1;
        tick();
        exp_pc("rs_hold", 32'h18);
        rst = 1'b1;
        tick();
        exp_rst("rs");
        rst = 1'b0;
        id_stop = 1'b0;
        #1;
        check("rs_rel.ice", {31'b0, ice}, 32'd1);
        check("rs_rel.valid", {31'b0, if_o_valid}, 32'd0);
        tick();
        exp_pc("rs0", 32'h0);
        tick();
        exp_pc("rs4", 32'h4);
        tick();
        exp_pc("rs8", 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
